rejunity_ternary_dot: RTL and testbench

Tiny Tapeout user block that computes 32-element dot products between ternary weights {-1, 0, +1} and binary activations {0, 1}. It accumulates the products into a saturating 14-bit signed register. Operands are streamed in byte-wide over `ui_in`, and `uio_in[1:0]` selects the target. The accumulator is driven continuously on `uo_out` and `uio_out[7:2]`. The per-element arithmetic is carried out by a combinational 32-bit population counter, `PopCount32`, which is also a standalone, separately testable sub-block.

---
 rtl/rejunity_ternary_dot.sv | 110 +++++++++++
 tb/tb_rejunity_ternary_dot.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rejunity_ternary_dot.sv
// rejunity_ternary_dot
//   Ternary-weight x binary-activation dot product engine, 32 elements wide.
//   Weight masks P (+1) and N (-1) and activation mask A are shifted in a
//   byte at a time. Commands fold dot = popcount(A&P) - popcount(A&N)
//   into a saturating 14-bit signed accumulator.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : async active-low reset, clears all state
//   ena     : block enable, all state holds when low
//   ui_in   : operand byte (SEL!=0) or command byte (SEL==0: [1]=CLR, [0]=ACC)
//   uio_in  : [1:0] = SEL (01:P, 10:N, 11:A, 00:command), [7:2] ignored
//   uo_out  : acc[7:0]
//   uio_out : {acc[13:8], 2'b00}
//   uio_oe  : constant 8'hFC (upper six bidirectional pins driven)
//
// PopCount32
//   data  : 32-bit word
//   count : number of set bits, 0..32, combinational

module PopCount32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);
  // Two-level adder tree: byte-wise counts, then sum of the four bytes.
  logic [3:0][3:0] byte_cnt;

  for (genvar g = 0; g < 4; g++) begin : g_byte
    always_comb begin
      byte_cnt[g] = 4'd0;
      for (int i = 0; i < 8; i++)
        byte_cnt[g] = byte_cnt[g] + {3'd0, data[g*8+i]};
    end
  end

  always_comb
    count = {2'd0, byte_cnt[0]} + {2'd0, byte_cnt[1]} +
            {2'd0, byte_cnt[2]} + {2'd0, byte_cnt[3]};
endmodule

module rejunity_ternary_dot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [1:0] SEL_CMD = 2'b00;
  localparam logic [1:0] SEL_P   = 2'b01;
  localparam logic [1:0] SEL_N   = 2'b10;
  localparam logic [1:0] SEL_A   = 2'b11;

  logic [31:0] p_q, n_q, a_q;
  logic [13:0] acc_q;
  logic [1:0]  sel;
  logic        cmd_clr, cmd_acc;

  logic [5:0]  pos_cnt, neg_cnt;
  logic [6:0]  dot;      // signed, -32..+32
  logic [13:0] dot_ext;
  logic [14:0] sum;      // one guard bit above acc
  logic [13:0] acc_sat;

  assign sel     = uio_in[1:0];
  assign cmd_clr = ui_in[1];
  assign cmd_acc = ui_in[0];

  PopCount32 u_pc_pos (.data(a_q & p_q), .count(pos_cnt));
  PopCount32 u_pc_neg (.data(a_q & n_q), .count(neg_cnt));

  // Elements with both masks set count once on each side and cancel out.
  assign dot     = {1'b0, pos_cnt} - {1'b0, neg_cnt};
  assign dot_ext = {{7{dot[6]}}, dot};
  assign sum     = {acc_q[13], acc_q} + {dot_ext[13], dot_ext};

  // |dot| <= 32, so overflow is visible as the guard bit disagreeing with
  // the 14-bit sign; clamp toward the side the guard bit names.
  always_comb begin
    acc_sat = sum[13:0];
    if (sum[14] != sum[13])
      acc_sat = sum[14] ? 14'h2000 : 14'h1FFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      n_q   <= '0;
      a_q   <= '0;
      acc_q <= '0;
    end else if (ena) begin
      case (sel)
        SEL_P:   p_q <= {p_q[23:0], ui_in};
        SEL_N:   n_q <= {n_q[23:0], ui_in};
        SEL_A:   a_q <= {a_q[23:0], ui_in};
        SEL_CMD: begin
          if (cmd_clr)      acc_q <= cmd_acc ? dot_ext : 14'd0;
          else if (cmd_acc) acc_q <= acc_sat;
        end
        default: ;
      endcase
    end
  end

  assign uo_out  = acc_q[7:0];
  assign uio_out = {acc_q[13:8], 2'b00};
  assign uio_oe  = 8'hFC;
endmodule

// File: tb/tb_rejunity_ternary_dot.sv
module tb_rejunity_ternary_dot;
  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  logic [31:0] pc_data;
  logic [5:0]  pc_count;

  int nvec = 0;
  int nerr = 0;

  rejunity_ternary_dot dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  PopCount32 u_pc (.data(pc_data), .count(pc_count));

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [15:0] rd_out();
    return {{3{uio_out[7]}}, uio_out[6:2], uo_out};
  endfunction

  // One enabled cycle with the given select and byte, then park on no-op.
  task automatic drive(input logic [1:0] sel, input logic [7:0] b);
    uio_in = {6'd0, sel};
    ui_in  = b;
    @(posedge clk); #1;
    uio_in = 8'd0;
    ui_in  = 8'd0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) drive(sel, w[i*8 +: 8]);
  endtask

  task automatic cmd(input logic [7:0] c);
    drive(2'b00, c);
  endtask

  task automatic chk(input string name, input logic [15:0] exp);
    nvec++;
    if (rd_out() !== exp || uio_out[1:0] !== 2'b00 || uio_oe !== 8'hFC) begin
      nerr++;
      $display("FAIL %s: got out=%h uio_out=%h uio_oe=%h, want out=%h uio[1:0]=0 oe=fc",
               name, rd_out(), uio_out, uio_oe, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'd0; uio_in = 8'd0;
    #1;
    chk("reset_async", 16'h0000);
    clk_run = 1'b1;
    #12 rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("reset_idle", 16'h0000);
  endtask

  task automatic test_positive();
    load(2'b01, 32'hFFFF_FFFF);
    load(2'b10, 32'h0000_0000);
    load(2'b11, 32'hFFFF_FFFF);
    cmd(8'h03); chk("pos_load", 16'd32);
    cmd(8'h01); chk("pos_acc", 16'd64);
    cmd(8'h00); chk("pos_nop", 16'd64);
    cmd(8'h02); chk("pos_clr", 16'd0);
  endtask

  task automatic test_neg_zero();
    load(2'b01, 32'h0000_0000);
    load(2'b10, 32'hFFFF_FFFF);
    load(2'b11, 32'h0000_000F);
    cmd(8'h03); chk("neg_dot", 16'hFFFC);
    cmd(8'h01); chk("neg_acc", 16'hFFF8);
    load(2'b01, 32'hFFFF_FFFF);
    cmd(8'h03); chk("both_masks", 16'h0000);
  endtask

  task automatic test_saturation();
    load(2'b01, 32'hFFFF_FFFF);
    load(2'b10, 32'h0000_0000);
    load(2'b11, 32'hFFFF_FFFF);
    cmd(8'h03);
    repeat (300) cmd(8'h01);
    chk("sat_pos", 16'd8191);
    cmd(8'h01); chk("sat_pos_hold", 16'd8191);
    // From the top rail, subtracting must leave the clamp normally.
    load(2'b01, 32'h0000_0000);
    load(2'b10, 32'hFFFF_FFFF);
    cmd(8'h01); chk("sat_leave", 16'd8159);
    cmd(8'h03);
    repeat (300) cmd(8'h01);
    chk("sat_neg", 16'hE000);
    cmd(8'h01); chk("sat_neg_hold", 16'hE000);
  endtask

  task automatic test_enable_order();
    // State now: P=0, N=ones, A=ones, acc=-8192.
    ena = 1'b0;
    load(2'b10, 32'h0000_0000);
    load(2'b11, 32'h0000_0000);
    cmd(8'h02);
    chk("ena_hold", 16'hE000);
    ena = 1'b1;
    cmd(8'h03); chk("ena_regs_kept", 16'hFFE0);
    load(2'b01, 32'h8000_0001);
    load(2'b10, 32'h0000_0000);
    drive(2'b11, 8'h80); drive(2'b11, 8'h00);
    drive(2'b11, 8'h00); drive(2'b11, 8'h01);
    cmd(8'h03); chk("byte_order", 16'd2);
    load(2'b01, 32'h8000_0000);
    cmd(8'h03); chk("byte_order_msb", 16'd1);
    // Partial A load, then reset mid-operation.
    drive(2'b11, 8'h12); drive(2'b11, 8'h34);
    #2 rst_n = 1'b0;
    #1 chk("reset_midload", 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load(2'b01, 32'hFFFF_FFFF);
    drive(2'b11, 8'hFF); drive(2'b11, 8'hFF);
    cmd(8'h03); chk("reset_discard", 16'd16);
  endtask

  task automatic test_popcount();
    logic [31:0] vec [4];
    logic [5:0]  exp [4];
    vec = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h8000_0001};
    exp = '{6'd0, 6'd32, 6'd16, 6'd2};
    for (int i = 0; i < 4; i++) begin
      pc_data = vec[i]; #1;
      nvec++;
      if (pc_count !== exp[i]) begin
        nerr++;
        $display("FAIL popcount_dir %h: got %0d want %0d", vec[i], pc_count, exp[i]);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      logic [5:0] ref_cnt;
      pc_data = $urandom;
      ref_cnt = 6'd0;
      for (int b = 0; b < 32; b++) ref_cnt = ref_cnt + {5'd0, pc_data[b]};
      #1;
      nvec++;
      if (pc_count !== ref_cnt) begin
        nerr++;
        $display("FAIL popcount_rand %h: got %0d want %0d", pc_data, pc_count, ref_cnt);
      end
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_positive();
        test_neg_zero();
        test_saturation();
        test_enable_order();
        test_popcount();
      end
      begin
        #1_000_000;
        $display("FAIL timeout: got no completion, want completion within 1ms");
        nerr++;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
